// File: rtl/row_unpack.sv
// Row unpacker: accepts one packed row of ROWLEN words and streams it out one word per
// handshake, word 0 first. The active row and one pending row are both held so rows stream back-to-back.
module row_unpack #(
  parameter int unsigned WORDWIDTH = 32,
  parameter int unsigned NUM1      = 14,
  parameter int unsigned NUM2      = 5,
  localparam int unsigned ROWLEN   = NUM1 + 1 - NUM2,
  localparam int unsigned IDXW     = (ROWLEN > 1) ? $clog2(ROWLEN) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ROWLEN*WORDWIDTH-1:0] row_in,
  input  logic                        row_valid,
  output logic                        row_ready,
  output logic [WORDWIDTH-1:0]        word_out,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic [IDXW-1:0]             word_idx,
  output logic                        word_last,
  output logic                        busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ROWLEN - 1);

  state_t state, state_nxt;
  logic [ROWLEN-1:0][WORDWIDTH-1:0] row_words, active_q, pend_q;
  logic [IDXW-1:0] idx_q, idx_inc;
  logic pend_full_q;
  logic [WORDWIDTH-1:0] word_q;
  logic last_q;
  logic row_hs, word_hs, is_last;
  logic load_in, load_pend, advance, store_pend;

  assign row_words  = row_in;
  assign idx_inc    = idx_q + IDXW'(1);
  assign is_last    = (idx_q == LAST_IDX);
  assign row_ready  = !rst && ((state == IDLE) || !pend_full_q);
  assign word_valid = (state == SEND);
  assign row_hs     = row_valid && row_ready;
  assign word_hs    = word_valid && word_ready;
  assign word_out   = word_q;
  assign word_idx   = idx_q;
  assign word_last  = last_q;
  assign busy       = (state == SEND) || pend_full_q;

  // Next state and row/word movement decisions
  always_comb begin
    state_nxt  = state;
    load_in    = 1'b0;
    load_pend  = 1'b0;
    advance    = 1'b0;
    store_pend = 1'b0;
    case (state)
      IDLE: begin
        if (row_hs) begin
          load_in   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (word_hs && is_last) begin
          if (pend_full_q)  load_pend = 1'b1;
          else if (row_hs)  load_in   = 1'b1;
          else              state_nxt = IDLE;
        end else if (word_hs) begin
          advance = 1'b1;
        end
        // Pending is never full here when row_hs is set, since row_ready drops
        if (row_hs && !load_in) store_pend = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      word_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_in) begin
        active_q <= row_words;
        idx_q    <= '0;
        word_q   <= row_words[0];
        last_q   <= (ROWLEN == 1);
      end
      if (load_pend) begin
        active_q    <= pend_q;
        pend_full_q <= 1'b0;
        idx_q       <= '0;
        word_q      <= pend_q[0];
        last_q      <= (ROWLEN == 1);
      end
      if (advance) begin
        idx_q  <= idx_inc;
        word_q <= active_q[idx_inc];
        last_q <= (idx_inc == LAST_IDX);
      end
      if (store_pend) begin
        pend_q      <= row_words;
        pend_full_q <= 1'b1;
      end
      if (state == SEND && state_nxt == IDLE) last_q <= 1'b0;
    end
  end

endmodule
